triangle_raster: RTL and testbench
==================================

# triangle_raster

Rasterises one triangle into the pixels it covers. Given three vertices, the block scans the triangle's bounding box and streams every covered (x, y) pixel to a downstream consumer through a valid/ready handshake. It is the pixel producer for the triangle path: the point-in-triangle tester answers whether one supplied point lies inside a triangle, and this block generates the full point set. The x/y ranges match the 11-bit screen coordinate space used by the point tester.

## Interface
- COORD_W, 11: unsigned coordinate width for vertices and pixels.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- ax, ay, bx, by, cx, cy  in  COORD_W each  vertex coordinates, unsigned; captured on the accepted start.
- out_x, out_y  out  COORD_W each  covered pixel coordinates.
- out_valid  out  1  out_x/out_y hold a covered pixel.
- out_ready  in  1  consumer accepts the pixel when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the triangle is finished.

## Operation
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE: start=1 latches the six vertices and moves to SETUP. start is ignored in every other state.
- SETUP (1 cycle):
  - Bounding box: xmin/xmax = min/max(ax, bx, cx); ymin/ymax likewise.
  - Area: area = E_ab(c). Scan counters load (xmin, ymin).
  - If area == 0, go to DONE and emit no pixels. Otherwise go to SCAN.
- Edge functions, for an edge from u to v evaluated at point p:
  - E_uv(p) = (vx-ux)*(py-uy) - (vy-uy)*(px-ux).
  - Differences: 12-bit signed, formed from zero-extended operands.
  - Products: 24-bit signed. Result: 25-bit signed. No truncation anywhere.
- Inside test for p = (sx, sy), with edges E_ab, E_bc, E_ca:
  - If area > 0, all three edges ≥ 0. If area < 0, all three edges ≤ 0.
  - Edges are inclusive, so pixels exactly on an edge or vertex are emitted.
- SCAN:
  - Advance condition: !out_valid || out_ready.
  - On advance, if the current candidate is inside, load it into out_x/out_y and set out_valid=1. Otherwise clear out_valid if it was just accepted.
  - Counters step in row-major order: sx increments; at xmax, sx returns to xmin and sy increments.
  - After the candidate (xmax, ymax) is evaluated, go to DRAIN.
  - While the advance condition is false, counters and outputs hold.
- DRAIN: wait until !out_valid, or until the pixel is accepted (out_valid && out_ready, which clears out_valid). Then go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Reset at any point: state returns to IDLE, the in-flight triangle is abandoned, and no done pulse is produced.
- Reset values: out_valid=0, out_x=0, out_y=0, busy=0, done=0, counters 0.

## Timing
- Start sampled at edge k: SETUP during k..k+1, SCAN from k+1.
- The first candidate (xmin, ymin) is evaluated at edge k+2. If covered, out_valid is high after k+2.
- Without backpressure, one candidate is evaluated per cycle: (xmax-xmin+1)*(ymax-ymin+1) SCAN cycles, then DRAIN and DONE.
- out_x/out_y stay stable while out_valid && !out_ready. There are no bubbles when out_ready is held high.
- Degenerate triangle: done pulses in the cycle after SETUP, i.e. the third cycle after start.
- The outputs are registered. out_valid never depends combinationally on out_ready.

## Structure
- Shared package `raster_pkg`:
  - COORD_W, EDGE_W (= 2*COORD_W + 3 = 25).
  - Scan state enum.
  - `coord_t` and `edge_t` typedefs.
- Sub-module `edge_fn`: purely combinational, inputs (ux, uy, vx, vy, px, py), output signed EDGE_W E_uv(p). Instantiated four times: the area term and three edges. The area instance may share with E_ab via a mux.

## Test plan
- Triangle (0,0), (4,0), (0,4), out_ready=1: exactly 15 pixels with x+y ≤ 4, in row-major order (0,0),(1,0)…(4,0),(0,1)…; then one done pulse.
- Same vertices in the order (0,0), (0,4), (4,0) (opposite winding): identical 15-pixel stream.
- Collinear (0,0), (2,2), (4,4), and also all vertices at (7,7): zero out_valid cycles; done three cycles after start.
- Triangle (0,0), (4,0), (0,4) with out_ready low for 5 cycles at the second pixel: (1,0) is held stable for all 5 cycles, the stream resumes afterwards, and the total is still 15.
- Corner triangle (2047,2047), (2046,2047), (2047,2046): exactly 3 pixels with no overflow; then done.
- Reset asserted mid-SCAN: out_valid and busy go low immediately and no done pulse follows. A new start then runs to completion with the correct count.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle rasteriser.
// Coordinates are unsigned 11-bit; edge values are 25-bit signed.
package raster_pkg;

  localparam int COORD_W = 11;
  localparam int EDGE_W  = 2*COORD_W + 3;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic coord_t min3(
    input coord_t a,
    input coord_t b,
    input coord_t c
  );
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(
    input coord_t a,
    input coord_t b,
    input coord_t c
  );
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/edge_fn.sv
// Edge function E_uv(p) = (vx-ux)*(py-uy) - (vy-uy)*(px-ux).
// Full precision: 12-bit diffs, 24-bit products, 25-bit result.
module edge_fn
  import raster_pkg::*;
(
  input  coord_t ux,
  input  coord_t uy,
  input  coord_t vx,
  input  coord_t vy,
  input  coord_t px,
  input  coord_t py,
  output edge_t  e
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2*COORD_W + 2;

  logic signed [DW-1:0] w_dvx;
  logic signed [DW-1:0] w_dvy;
  logic signed [DW-1:0] w_dpx;
  logic signed [DW-1:0] w_dpy;
  logic signed [PW-1:0] w_p1;
  logic signed [PW-1:0] w_p2;

  assign w_dvx = {1'b0, vx} - {1'b0, ux};
  assign w_dvy = {1'b0, vy} - {1'b0, uy};
  assign w_dpx = {1'b0, px} - {1'b0, ux};
  assign w_dpy = {1'b0, py} - {1'b0, uy};

  // Operands widened first so the products never wrap.
  assign w_p1 = PW'(w_dvx) * PW'(w_dpy);
  assign w_p2 = PW'(w_dvy) * PW'(w_dpx);

  assign e = {w_p1[PW-1], w_p1} - {w_p2[PW-1], w_p2};

endmodule

// File: rtl/triangle_raster.sv
// Scans a triangle's bounding box and streams covered pixels
// over a registered valid/ready output.
module triangle_raster
  import raster_pkg::*;
(
  input  logic   CLOCK_50,
  input  logic   reset,
  input  logic   start,
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  input  coord_t cx,
  input  coord_t cy,
  output coord_t out_x,
  output coord_t out_y,
  output logic   out_valid,
  input  logic   out_ready,
  output logic   busy,
  output logic   done
);

  state_t r_state;
  state_t w_next;

  coord_t r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
  coord_t r_xmin, r_xmax, r_ymax;
  coord_t r_sx, r_sy;
  coord_t r_out_x, r_out_y;
  logic   r_neg;
  logic   r_out_valid;

  edge_t w_area, w_eab, w_ebc, w_eca;
  logic  w_ge, w_le, w_inside, w_adv, w_last;

  localparam int MSB = EDGE_W - 1;

  edge_fn u_area (
    .ux(r_ax), .uy(r_ay), .vx(r_bx), .vy(r_by),
    .px(r_cx), .py(r_cy), .e(w_area)
  );
  edge_fn u_eab (
    .ux(r_ax), .uy(r_ay), .vx(r_bx), .vy(r_by),
    .px(r_sx), .py(r_sy), .e(w_eab)
  );
  edge_fn u_ebc (
    .ux(r_bx), .uy(r_by), .vx(r_cx), .vy(r_cy),
    .px(r_sx), .py(r_sy), .e(w_ebc)
  );
  edge_fn u_eca (
    .ux(r_cx), .uy(r_cy), .vx(r_ax), .vy(r_ay),
    .px(r_sx), .py(r_sy), .e(w_eca)
  );

  assign w_ge = !w_eab[MSB] && !w_ebc[MSB] && !w_eca[MSB];
  assign w_le = (w_eab[MSB] || w_eab == '0)
             && (w_ebc[MSB] || w_ebc == '0)
             && (w_eca[MSB] || w_eca == '0);
  // Winding decides which half-plane counts as inside.
  assign w_inside = r_neg ? w_le : w_ge;
  assign w_adv    = !r_out_valid || out_ready;
  assign w_last   = (r_sx == r_xmax) && (r_sy == r_ymax);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: w_next = (w_area == '0) ? S_DONE : S_SCAN;
      S_SCAN:  if (w_adv && w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_adv) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_ax <= '0; r_ay <= '0;
      r_bx <= '0; r_by <= '0;
      r_cx <= '0; r_cy <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymax <= '0;
      r_sx <= '0; r_sy <= '0;
      r_neg <= 1'b0;
      r_out_x <= '0; r_out_y <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_ax <= ax; r_ay <= ay;
        r_bx <= bx; r_by <= by;
        r_cx <= cx; r_cy <= cy;
      end
      if (r_state == S_SETUP) begin
        r_xmin <= min3(r_ax, r_bx, r_cx);
        r_xmax <= max3(r_ax, r_bx, r_cx);
        r_ymax <= max3(r_ay, r_by, r_cy);
        r_sx   <= min3(r_ax, r_bx, r_cx);
        r_sy   <= min3(r_ay, r_by, r_cy);
        r_neg  <= w_area[MSB];
      end
      if (r_state == S_SCAN && w_adv) begin
        r_out_valid <= w_inside;
        if (w_inside) begin
          r_out_x <= r_sx;
          r_out_y <= r_sy;
        end
        if (!w_last) begin
          if (r_sx == r_xmax) begin
            r_sx <= r_xmin;
            r_sy <= r_sy + coord_t'(1);
          end else begin
            r_sx <= r_sx + coord_t'(1);
          end
        end
      end
      if (r_state == S_DRAIN && out_ready)
        r_out_valid <= 1'b0;
    end
  end

  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_triangle_raster.sv
// Scoreboard bench for triangle_raster: expected pixel stream
// is queued at launch and popped on each accepted handshake.
module tb_triangle_raster;
  import raster_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   start = 1'b0;
  logic   out_ready = 1'b1;
  coord_t ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
  coord_t out_x, out_y;
  logic   out_valid, busy, done;

  triangle_raster dut (
    .CLOCK_50(clk), .reset(rst), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc = 0;
  int n_acc = 0, n_done = 0, n_vcyc = 0, done_cyc = 0;
  logic [21:0] q[$];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic longint efn(input int ux, input int uy,
    input int vx, input int vy, input int px, input int py);
    return longint'(vx-ux)*longint'(py-uy)
         - longint'(vy-uy)*longint'(px-ux);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (out_valid) n_vcyc++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("extra_px", 1, 0);
      else check("px", {out_x, out_y}, q.pop_front());
      n_acc++;
    end
  end

  task automatic build(input int a_x, input int a_y,
    input int b_x, input int b_y, input int c_x, input int c_y,
    output int nbox, output bit deg);
    int x0, x1, y0, y1;
    longint area, e0, e1, e2;
    bit in;
    x0 = a_x; x1 = a_x; y0 = a_y; y1 = a_y;
    if (b_x < x0) x0 = b_x; if (c_x < x0) x0 = c_x;
    if (b_x > x1) x1 = b_x; if (c_x > x1) x1 = c_x;
    if (b_y < y0) y0 = b_y; if (c_y < y0) y0 = c_y;
    if (b_y > y1) y1 = b_y; if (c_y > y1) y1 = c_y;
    nbox = (x1-x0+1)*(y1-y0+1);
    area = efn(a_x, a_y, b_x, b_y, c_x, c_y);
    deg  = (area == 0);
    if (!deg)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++) begin
          e0 = efn(a_x, a_y, b_x, b_y, x, y);
          e1 = efn(b_x, b_y, c_x, c_y, x, y);
          e2 = efn(c_x, c_y, a_x, a_y, x, y);
          if (area > 0) in = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
          else          in = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
          if (in) q.push_back({11'(x), 11'(y)});
        end
  endtask

  task automatic launch(input int a_x, input int a_y,
    input int b_x, input int b_y, input int c_x, input int c_y,
    output int k);
    @(posedge clk); #1;
    ax = coord_t'(a_x); ay = coord_t'(a_y);
    bx = coord_t'(b_x); by = coord_t'(b_y);
    cx = coord_t'(c_x); cy = coord_t'(c_y);
    start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic run_tri(input int a_x, input int a_y,
    input int b_x, input int b_y, input int c_x, input int c_y,
    input int exp_n, input int stall);
    int k, nbox;
    bit deg, stalled, to;
    logic [21:0] held;
    stalled = 0; to = 1;
    q.delete();
    n_acc = 0; n_done = 0; n_vcyc = 0;
    build(a_x, a_y, b_x, b_y, c_x, c_y, nbox, deg);
    check("model_n", q.size(), exp_n);
    launch(a_x, a_y, b_x, b_y, c_x, c_y, k);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (stall >= 0 && !stalled && n_acc == stall && out_valid) begin
        out_ready = 1'b0;
        held = {out_x, out_y};
        for (int j = 0; j < 5; j++) begin
          @(posedge clk); #1;
          check("hold_v", out_valid, 1);
          check("hold_xy", {out_x, out_y}, held);
        end
        out_ready = 1'b1;
        stalled = 1;
      end
      if (n_done != 0) begin
        to = 0;
        break;
      end
    end
    check("timeout", to, 0);
    check("count", n_acc, exp_n);
    check("vcyc", n_vcyc, exp_n + ((stall >= 0) ? 5 : 0));
    check("done_n", n_done, 1);
    check("q_left", q.size(), 0);
    if (stall >= 0) check("stalled", stalled, 1);
    else check("done_t", done_cyc - k, deg ? 1 : nbox + 2);
    repeat (2) @(posedge clk);
    #1 check("idle_busy", busy, 0);
  endtask

  initial begin
    int k, nbox;
    bit deg;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    run_tri(0, 0, 4, 0, 0, 4, 15, -1);
    run_tri(0, 0, 0, 4, 4, 0, 15, -1);
    run_tri(0, 0, 2, 2, 4, 4, 0, -1);
    run_tri(7, 7, 7, 7, 7, 7, 0, -1);
    run_tri(0, 0, 4, 0, 0, 4, 15, 1);
    run_tri(2047, 2047, 2046, 2047, 2047, 2046, 3, -1);

    q.delete();
    n_done = 0;
    build(0, 0, 40, 0, 0, 40, nbox, deg);
    launch(0, 0, 40, 0, 0, 40, k);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", out_x, 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("mid_rst_nodone", n_done, 0);

    run_tri(0, 0, 4, 0, 0, 4, 15, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
